// File: rtl/rifl_link_bringup_ctrl.sv
// -----------------------------------------------------------------------------
// rifl_link_bringup_ctrl
//
// Purpose:
//   This sequencer runs in the init clock domain. It brings up the RIFL GT link
//   and then keeps watching it. It drives the GT full reset and the rx datapath
//   reset. Each wait stage has its own timeout. An rx-side failure first gets a
//   bounded number of rx-only retries before the controller escalates to a full
//   reset. Link loss is detected through a glitch filter on rx_aligned.
//
// Ports:
//   i_clk              free-running init clock
//   i_rst_n            asynchronous active-low reset
//   i_enable           1 = bring the link up, 0 = hold the GT in reset
//   i_clock_active     tx & rx usrclk active (async, synchronized here)
//   i_tx_done          tx reset done & tx buffer bypass done (async)
//   i_rx_done          rx reset done & rx buffer bypass done (async)
//   i_rx_aligned       lane/frame alignment achieved (async)
//   o_gt_init_rst      GT full reset, active high
//   o_rx_datapath_rst  GT rx datapath reset, active high
//   o_link_up          link usable
//   o_state            current FSM state encoding
//   o_retry_cnt        rx retries in the current attempt
//   o_link_drop_cnt    link-loss events        (statistics build only)
//   o_full_rst_cnt     non-IDLE full resets    (statistics build only)
//
// Configuration macro:
//   RIFL_BRINGUP_STATS_EN - builds the two saturating statistics counters.
//   When the macro is undefined, both statistics ports are tied to zero.
// -----------------------------------------------------------------------------
module rifl_link_bringup_ctrl #(
  parameter int RST_CYCLES    = 16,
  parameter int TIMEOUT_WIDTH = 20,
  parameter int MAX_RX_RETRY  = 4,
  parameter int LOSS_FILTER   = 8
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic                              i_enable,
  input  logic                              i_clock_active,
  input  logic                              i_tx_done,
  input  logic                              i_rx_done,
  input  logic                              i_rx_aligned,
  output logic                              o_gt_init_rst,
  output logic                              o_rx_datapath_rst,
  output logic                              o_link_up,
  output logic [2:0]                        o_state,
  output logic [$clog2(MAX_RX_RETRY+1)-1:0] o_retry_cnt,
  output logic [15:0]                       o_link_drop_cnt,
  output logic [15:0]                       o_full_rst_cnt
);

  localparam int RW = $clog2(MAX_RX_RETRY + 1);
  localparam int FW = $clog2(LOSS_FILTER + 1);
  localparam int TW = TIMEOUT_WIDTH;

  localparam logic [TW-1:0] TIMER_ONE  = TW'(32'd1);
  localparam logic [TW-1:0] TIMER_MAX  = {TW{1'b1}};
  // A wait stage lasts 2^TW-1 cycles. It leaves on the edge at which the
  // timer would reach its maximum value.
  localparam logic [TW-1:0] TIMER_LAST = TIMER_MAX - TIMER_ONE;
  localparam logic [TW-1:0] HOLD_LAST  = TW'(RST_CYCLES - 32'sd1);
  localparam logic [RW-1:0] RETRY_ONE  = RW'(32'd1);
  localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RX_RETRY);
  localparam logic [FW-1:0] LOSS_ONE   = FW'(32'd1);
  localparam logic [FW-1:0] LOSS_LAST  = FW'(LOSS_FILTER - 32'sd1);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_RST_ALL    = 3'd1,
    ST_WAIT_CLK   = 3'd2,
    ST_WAIT_TX    = 3'd3,
    ST_WAIT_RX    = 3'd4,
    ST_WAIT_ALIGN = 3'd5,
    ST_RX_RST     = 3'd6,
    ST_LINK_UP    = 3'd7
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [3:0]      r_sync1;
  logic [3:0]      r_sync2;
  logic [TW-1:0]   r_timer;
  logic [RW-1:0]   r_retry_cnt;
  logic [RW-1:0]   w_next_retry;
  logic [RW-1:0]   w_retry_inc;
  logic [FW-1:0]   r_loss_cnt;
  logic            r_gt_init_rst;
  logic            r_rx_datapath_rst;
  logic            r_link_up;
  logic            w_clock_active_s;
  logic            w_tx_done_s;
  logic            w_rx_done_s;
  logic            w_rx_aligned_s;
  logic            w_hold_done;
  logic            w_timeout;
  logic            w_base_lost;
  logic            w_align_lost;
  logic            w_timed_state;

  // Two-flop synchronizers for the four asynchronous GT status inputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 4'b0000;
      r_sync2 <= 4'b0000;
    end else begin
      r_sync1 <= {i_rx_aligned, i_rx_done, i_tx_done, i_clock_active};
      r_sync2 <= r_sync1;
    end
  end

  assign w_clock_active_s = r_sync2[0];
  assign w_tx_done_s      = r_sync2[1];
  assign w_rx_done_s      = r_sync2[2];
  assign w_rx_aligned_s   = r_sync2[3];

  assign w_hold_done   = (r_timer == HOLD_LAST);
  assign w_timeout     = (r_timer == TIMER_LAST);
  // When the clocks or tx fall away, rx-only recovery is pointless.
  assign w_base_lost   = !(w_clock_active_s && w_tx_done_s);
  assign w_align_lost  = !w_rx_aligned_s && (r_loss_cnt == LOSS_LAST);
  assign w_retry_inc   = r_retry_cnt + RETRY_ONE;
  assign w_timed_state = (r_state == ST_RST_ALL)  || (r_state == ST_WAIT_CLK)   ||
                         (r_state == ST_WAIT_TX)  || (r_state == ST_WAIT_RX)    ||
                         (r_state == ST_WAIT_ALIGN) || (r_state == ST_RX_RST);

  // Next-state and next-retry decision. The order inside each state gives the
  // priority: enable first, then loss, then success, then timeout.
  always_comb begin
    w_next       = r_state;
    w_next_retry = r_retry_cnt;
    if (!i_enable) begin
      w_next       = ST_IDLE;
      w_next_retry = {RW{1'b0}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_next = ST_RST_ALL;
        end
        ST_RST_ALL: begin
          if (w_hold_done) begin
            w_next       = ST_WAIT_CLK;
            w_next_retry = {RW{1'b0}};
          end else begin
            w_next = ST_RST_ALL;
          end
        end
        ST_WAIT_CLK: begin
          if (w_clock_active_s) begin
            w_next = ST_WAIT_TX;
          end else if (w_timeout) begin
            w_next = ST_RST_ALL;
          end else begin
            w_next = ST_WAIT_CLK;
          end
        end
        ST_WAIT_TX: begin
          if (w_tx_done_s) begin
            w_next = ST_WAIT_RX;
          end else if (w_timeout) begin
            w_next = ST_RST_ALL;
          end else begin
            w_next = ST_WAIT_TX;
          end
        end
        ST_WAIT_RX: begin
          if (w_base_lost) begin
            w_next = ST_RST_ALL;
          end else if (w_rx_done_s) begin
            w_next = ST_WAIT_ALIGN;
          end else if (w_timeout) begin
            w_next = ST_RX_RST;
          end else begin
            w_next = ST_WAIT_RX;
          end
        end
        ST_WAIT_ALIGN: begin
          if (w_base_lost) begin
            w_next = ST_RST_ALL;
          end else if (w_rx_aligned_s) begin
            w_next       = ST_LINK_UP;
            w_next_retry = {RW{1'b0}};
          end else if (w_timeout) begin
            w_next = ST_RX_RST;
          end else begin
            w_next = ST_WAIT_ALIGN;
          end
        end
        ST_RX_RST: begin
          if (w_hold_done) begin
            w_next_retry = w_retry_inc;
            // Running out of rx-only attempts escalates to a full GT reset.
            if (w_retry_inc == RETRY_MAX) begin
              w_next = ST_RST_ALL;
            end else begin
              w_next = ST_WAIT_RX;
            end
          end else begin
            w_next = ST_RX_RST;
          end
        end
        ST_LINK_UP: begin
          if (w_base_lost) begin
            w_next = ST_RST_ALL;
          end else if (!w_rx_done_s) begin
            w_next = ST_WAIT_RX;
          end else if (w_align_lost) begin
            w_next = ST_WAIT_ALIGN;
          end else begin
            w_next = ST_LINK_UP;
          end
        end
        default: begin
          w_next       = ST_IDLE;
          w_next_retry = {RW{1'b0}};
        end
      endcase
    end
  end

  // Main FSM register, with the outputs decoded from the next state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state           <= ST_IDLE;
      r_retry_cnt       <= {RW{1'b0}};
      r_gt_init_rst     <= 1'b1;
      r_rx_datapath_rst <= 1'b0;
      r_link_up         <= 1'b0;
    end else begin
      r_state           <= w_next;
      r_retry_cnt       <= w_next_retry;
      r_gt_init_rst     <= (w_next == ST_IDLE) || (w_next == ST_RST_ALL);
      r_rx_datapath_rst <= (w_next == ST_RX_RST);
      r_link_up         <= (w_next == ST_LINK_UP);
    end
  end

  // The stage timer doubles as the reset hold counter. The loss filter counts
  // consecutive cycles with rx_aligned low while the link is up.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_timer    <= {TW{1'b0}};
      r_loss_cnt <= {FW{1'b0}};
    end else begin
      if (w_next != r_state) begin
        r_timer <= {TW{1'b0}};
      end else if (w_timed_state && (r_timer != TIMER_MAX)) begin
        r_timer <= r_timer + TIMER_ONE;
      end else if (w_timed_state) begin
        r_timer <= r_timer;
      end else begin
        r_timer <= {TW{1'b0}};
      end

      if ((r_state == ST_LINK_UP) && (w_next == ST_LINK_UP) && !w_rx_aligned_s) begin
        r_loss_cnt <= r_loss_cnt + LOSS_ONE;
      end else begin
        r_loss_cnt <= {FW{1'b0}};
      end
    end
  end

`ifdef RIFL_BRINGUP_STATS_EN
  logic [15:0] r_link_drop_cnt;
  logic [15:0] r_full_rst_cnt;

  // Saturating link-drop and full-reset statistics. Only rst_n clears them.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_link_drop_cnt <= 16'h0000;
      r_full_rst_cnt  <= 16'h0000;
    end else begin
      if ((r_state == ST_LINK_UP) && (w_next != ST_LINK_UP) && i_enable &&
          (r_link_drop_cnt != 16'hFFFF)) begin
        r_link_drop_cnt <= r_link_drop_cnt + 16'h0001;
      end else begin
        r_link_drop_cnt <= r_link_drop_cnt;
      end
      // An entry from IDLE is the normal start-up and is not counted.
      if ((w_next == ST_RST_ALL) && (r_state != ST_RST_ALL) && (r_state != ST_IDLE) &&
          (r_full_rst_cnt != 16'hFFFF)) begin
        r_full_rst_cnt <= r_full_rst_cnt + 16'h0001;
      end else begin
        r_full_rst_cnt <= r_full_rst_cnt;
      end
    end
  end

  assign o_link_drop_cnt = r_link_drop_cnt;
  assign o_full_rst_cnt  = r_full_rst_cnt;
`else
  assign o_link_drop_cnt = 16'h0000;
  assign o_full_rst_cnt  = 16'h0000;
`endif

  assign o_state           = r_state;
  assign o_retry_cnt       = r_retry_cnt;
  assign o_gt_init_rst     = r_gt_init_rst;
  assign o_rx_datapath_rst = r_rx_datapath_rst;
  assign o_link_up         = r_link_up;

endmodule

// File: tb/tb_rifl_link_bringup_ctrl.sv
// -----------------------------------------------------------------------------
// Self-checking bench for rifl_link_bringup_ctrl. The bench is built with
// RST_CYCLES=4, TIMEOUT_WIDTH=6, MAX_RX_RETRY=2 and LOSS_FILTER=3.
// -----------------------------------------------------------------------------
module tb_rifl_link_bringup_ctrl;

  localparam int P_RST = 4;
  localparam int P_TW  = 6;
  localparam int P_MR  = 2;
  localparam int P_LF  = 3;
  localparam int P_TMO = (1 << P_TW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b1, ca = 1'b1, tx = 1'b1, rx = 1'b1, al = 1'b1;
  logic gt, rxr, lu;
  logic [2:0] st;
  logic [1:0] retry;
  logic [15:0] drops, fulls;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  rifl_link_bringup_ctrl #(
    .RST_CYCLES(P_RST), .TIMEOUT_WIDTH(P_TW), .MAX_RX_RETRY(P_MR), .LOSS_FILTER(P_LF)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(en), .i_clock_active(ca),
    .i_tx_done(tx), .i_rx_done(rx), .i_rx_aligned(al),
    .o_gt_init_rst(gt), .o_rx_datapath_rst(rxr), .o_link_up(lu), .o_state(st),
    .o_retry_cnt(retry), .o_link_drop_cnt(drops), .o_full_rst_cnt(fulls)
  );

  // Reference model: the state is a stage number, the elapsed time is the
  // number of cycles spent in the stage, and each synchronizer is a two-entry
  // delay line of input snapshots.
  int m_st, m_n, m_retry, m_low, m_drops, m_fulls;
  logic [3:0] m_d0, m_d1;

  task automatic model_reset();
    m_st = 0; m_n = 0; m_retry = 0; m_low = 0; m_drops = 0; m_fulls = 0;
    m_d0 = 4'b0000; m_d1 = 4'b0000;
  endtask

  task automatic model_step();
    logic [3:0] syn;
    logic s_ca, s_tx, s_rx, s_al, base;
    int cur, nx, nr;
    syn  = m_d1;
    m_d1 = m_d0;
    m_d0 = {al, rx, tx, ca};
    s_ca = syn[0]; s_tx = syn[1]; s_rx = syn[2]; s_al = syn[3];
    base = s_ca && s_tx;
    cur = m_st; nx = cur; nr = m_retry;
    if (!en) begin
      nx = 0; nr = 0;
    end else begin
      case (cur)
        0: nx = 1;
        1: if (m_n + 1 == P_RST) begin nx = 2; nr = 0; end
        2: if (s_ca) nx = 3; else if (m_n + 1 == P_TMO) nx = 1;
        3: if (s_tx) nx = 4; else if (m_n + 1 == P_TMO) nx = 1;
        4: if (!base) nx = 1; else if (s_rx) nx = 5; else if (m_n + 1 == P_TMO) nx = 6;
        5: if (!base) nx = 1; else if (s_al) begin nx = 7; nr = 0; end
           else if (m_n + 1 == P_TMO) nx = 6;
        6: if (m_n + 1 == P_RST) begin
             nr = m_retry + 1;
             nx = (nr == P_MR) ? 1 : 4;
           end
        7: if (!base) nx = 1; else if (!s_rx) nx = 4;
           else if (!s_al && (m_low + 1 == P_LF)) nx = 5;
        default: nx = 0;
      endcase
    end
    m_low = (cur == 7 && nx == 7 && !s_al) ? m_low + 1 : 0;
    if (nx == 1 && cur != 1 && cur != 0 && m_fulls < 65535) m_fulls++;
    if (cur == 7 && nx != 7 && en && m_drops < 65535) m_drops++;
    m_n = (nx == cur) ? m_n + 1 : 0;
    m_st = nx; m_retry = nr;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int stat_exp(input int v);
`ifdef RIFL_BRINGUP_STATS_EN
    return v;
`else
    return 0;
`endif
  endfunction

  task automatic model_cmp();
    chk("model_state", int'(st), m_st);
    chk("model_gt_init_rst", int'(gt), (m_st <= 1) ? 1 : 0);
    chk("model_rx_datapath_rst", int'(rxr), (m_st == 6) ? 1 : 0);
    chk("model_link_up", int'(lu), (m_st == 7) ? 1 : 0);
    chk("model_retry_cnt", int'(retry), m_retry);
    chk("model_link_drop_cnt", int'(drops), stat_exp(m_drops));
    chk("model_full_rst_cnt", int'(fulls), stat_exp(m_fulls));
  endtask

  // The model steps on the same posedge as the DUT. The outputs are compared
  // on the following negedge. Inputs change only at the negedge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      if (rst_n) model_step();
      @(negedge clk);
      model_cmp();
    end
  endtask

  task automatic set_in(input logic e, input logic c, input logic t, input logic r, input logic a);
    en = e; ca = c; tx = t; rx = r; al = a;
  endtask

  task automatic wait_state(input int s, input int bound);
    for (int i = 0; i < bound && int'(st) != s; i++) tick(1);
    chk("wait_state", int'(st), s);
  endtask

  typedef struct {
    logic en, ca, tx, rx, al;
    int n;
    int st, gt, rr, lu, retry, drops, fulls;
  } vec_t;

  function automatic vec_t mk(input logic e, input logic c, input logic t, input logic r,
                              input logic a, input int n, input int s, input int g,
                              input int rr, input int l, input int d, input int f);
    vec_t v;
    v.en = e; v.ca = c; v.tx = t; v.rx = r; v.al = a; v.n = n;
    v.st = s; v.gt = g; v.rr = rr; v.lu = l; v.retry = 0; v.drops = d; v.fulls = f;
    return v;
  endfunction

  vec_t tbl[16];

  initial begin
    int w;
    // Rows: inputs, cycles to hold them, then the expected outputs.
    tbl[0]  = mk(1,1,1,1,1,  1, 1,1,0,0, 0,0); // IDLE -> RST_ALL
    tbl[1]  = mk(1,1,1,1,1,  3, 1,1,0,0, 0,0); // hold for 4 cycles
    tbl[2]  = mk(1,1,1,1,1,  1, 2,0,0,0, 0,0); // WAIT_CLK
    tbl[3]  = mk(1,1,1,1,1,  1, 3,0,0,0, 0,0);
    tbl[4]  = mk(1,1,1,1,1,  1, 4,0,0,0, 0,0);
    tbl[5]  = mk(1,1,1,1,1,  1, 5,0,0,0, 0,0);
    tbl[6]  = mk(1,1,1,1,1,  1, 7,0,0,1, 0,0); // LINK_UP
    tbl[7]  = mk(1,1,1,1,1,  5, 7,0,0,1, 0,0);
    tbl[8]  = mk(1,1,0,1,1,  2, 7,0,0,1, 0,0); // tx fall still in the sync
    tbl[9]  = mk(1,1,0,1,1,  1, 1,1,0,0, 1,1); // third edge: full reset
    tbl[10] = mk(1,1,0,1,1,  4, 2,0,0,0, 1,1);
    tbl[11] = mk(1,1,0,1,1,  1, 3,0,0,0, 1,1);
    tbl[12] = mk(1,1,0,1,1, 62, 3,0,0,0, 1,1); // one cycle before the timeout
    tbl[13] = mk(1,1,0,1,1,  1, 1,1,0,0, 1,2); // WAIT_TX timeout
    tbl[14] = mk(0,1,0,1,1,  1, 0,1,0,0, 1,2); // enable low -> IDLE
    tbl[15] = mk(1,1,0,1,1,  1, 1,1,0,0, 1,2);

    model_reset();
    set_in(1, 1, 1, 1, 1);
    tick(2);
    chk("reset_state", int'(st), 0);
    chk("reset_gt_init_rst", int'(gt), 1);
    chk("reset_link_up", int'(lu), 0);
    rst_n = 1'b1;

    for (int r = 0; r < 16; r++) begin
      set_in(tbl[r].en, tbl[r].ca, tbl[r].tx, tbl[r].rx, tbl[r].al);
      tick(tbl[r].n);
      chk($sformatf("vec%0d_state", r), int'(st), tbl[r].st);
      chk($sformatf("vec%0d_gt", r), int'(gt), tbl[r].gt);
      chk($sformatf("vec%0d_rxrst", r), int'(rxr), tbl[r].rr);
      chk($sformatf("vec%0d_link_up", r), int'(lu), tbl[r].lu);
      chk($sformatf("vec%0d_retry", r), int'(retry), tbl[r].retry);
      chk($sformatf("vec%0d_drops", r), int'(drops), stat_exp(tbl[r].drops));
      chk($sformatf("vec%0d_fulls", r), int'(fulls), stat_exp(tbl[r].fulls));
    end

    // Pulse rst_n in the middle of WAIT_TX. The outputs must clear with no clock edge.
    tick(5);
    chk("pre_areset_state", int'(st), 3);
    #1 rst_n = 1'b0;
    #1;
    chk("areset_state", int'(st), 0);
    chk("areset_gt", int'(gt), 1);
    chk("areset_rxrst", int'(rxr), 0);
    chk("areset_link_up", int'(lu), 0);
    chk("areset_fulls", int'(fulls), 0);
    model_reset();
    tick(2);
    rst_n = 1'b1;

    // rx_aligned is held low: two rx resets, then escalation.
    set_in(1, 1, 1, 1, 0);
    wait_state(6, 100);
    w = 0;
    while (rxr && w < 20) begin w++; tick(1); end
    chk("rx_pulse1_width", w, P_RST);
    chk("rx_pulse1_retry", int'(retry), 1);
    chk("rx_pulse1_next_state", int'(st), 4);
    wait_state(6, 100);
    w = 0;
    while (rxr && w < 20) begin w++; tick(1); end
    chk("rx_pulse2_width", w, P_RST);
    chk("escalate_state", int'(st), 1);
    chk("escalate_gt", int'(gt), 1);
    chk("escalate_retry", int'(retry), 2);
    chk("escalate_fulls", int'(fulls), stat_exp(1));
    tick(P_RST);
    chk("after_rst_all_state", int'(st), 2);
    chk("after_rst_all_retry", int'(retry), 0);

    // Loss filter: a 2-cycle dip is ignored. A 3-cycle dip drops the link.
    al = 1'b1;
    wait_state(7, 20);
    al = 1'b0;
    tick(2);
    al = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      chk("glitch_link_up", int'(lu), 1);
    end
    al = 1'b0;
    tick(4);
    chk("loss_pending_state", int'(st), 7);
    tick(1);
    chk("loss_state", int'(st), 5);
    chk("loss_link_up", int'(lu), 0);
    chk("loss_drops", int'(drops), stat_exp(1));

    // enable is dropped in the middle of RX_RST.
    wait_state(6, 100);
    tick(1);
    en = 1'b0;
    tick(1);
    chk("en_drop_state", int'(st), 0);
    chk("en_drop_rxrst", int'(rxr), 0);
    chk("en_drop_gt", int'(gt), 1);
    chk("en_drop_retry", int'(retry), 0);

    // Randomized segments are checked cycle by cycle against the model.
    rst_n = 1'b0;
    model_reset();
    tick(2);
    rst_n = 1'b1;
    for (int s = 0; s < 120; s++) begin
      set_in(($urandom_range(0, 19) != 0), ($urandom_range(0, 29) != 0),
             ($urandom_range(0, 29) != 0), ($urandom_range(0, 9) != 0),
             ($urandom_range(0, 5) != 0));
      tick($urandom_range(1, 70));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
